// File: rtl/clock_pkg.sv
// Shared definitions for the time-setting button path: per-channel FSM
// state encoding and default timing constants for a 50 MHz MCLK.
package clock_pkg;

    // Per-button conditioner states.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        DB_PRESS   = 3'd1,
        HELD       = 3'd2,
        REPEAT     = 3'd3,
        BLOCKED    = 3'd4,
        DB_RELEASE = 3'd5
    } btn_state_t;

    // System clock frequency the defaults below are derived from.
    localparam int MCLK_HZ = 50_000_000;

    // 1 ms of stable level accepts a press or a release.
    localparam int DEBOUNCE_CYCLES_DEF = MCLK_HZ / 1000;

    // 0.5 s of holding after the first step before auto-repeat kicks in.
    localparam int HOLD_CYCLES_DEF = MCLK_HZ / 2;

    // 0.2 s between auto-repeat steps (5 steps per second).
    localparam int REPEAT_CYCLES_DEF = MCLK_HZ / 5;

    // Timer width; 25 bits covers the largest default (25,000,000).
    localparam int CNT_W_DEF = 25;

endpackage

// File: rtl/button_channel.sv
// One push-button conditioner: 2-FF synchroniser, debounce FSM with a
// saturating timer, press-and-hold auto-repeat and the hooks needed for
// plus/minus lockout against a sibling channel.
//
// Lockout handshake with the sibling (level signals, no valid/ready):
//   in_hold       - this channel owns the button pair (HELD or REPEAT).
//   debounce_done - single-cycle strobe: this channel's press debounce
//                   completes this cycle. If the sibling is in_hold or
//                   strobes debounce_done in the same cycle, the press is
//                   diverted to BLOCKED instead of producing a step.
// Both flags are derived from registered state only, so cross-wiring two
// channels creates no combinational loop.
module button_channel
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_n,
    input  logic       other_in_hold,
    input  logic       other_debounce_done,
    output logic       pulse,
    output logic       in_hold,
    output logic       debounce_done,
    output logic [2:0] state_dbg
);

    // Terminal timer values for each timed phase.
    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMR_MAX   = {CNT_W{1'b1}};

    logic             sync_q1;
    logic             sync_q2;
    logic             press;
    logic [1:0]       fill;
    logic             armed;
    btn_state_t       state;
    btn_state_t       state_nx;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nx;
    logic [CNT_W-1:0] timer_inc;
    logic             fire;

    // Two-stage synchroniser; resets to the released level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= btn_n;
            sync_q2 <= sync_q1;
        end
    end

    assign press = ~sync_q2;

    // Arming: after reset the synchroniser holds a forced "released" value
    // for two cycles. fill marks when sync_q2 really reflects the pin, and
    // armed is only set once the pin itself has been seen released. This
    // stops a button held through reset from producing a step.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fill  <= 2'b00;
            armed <= 1'b0;
        end else begin
            fill <= {fill[0], 1'b1};
            if (fill[1] && sync_q2) begin
                armed <= 1'b1;
            end
        end
    end

    // Saturating increment: a timer parked at its maximum never wraps.
    assign timer_inc = (timer == TMR_MAX) ? timer : timer + 1'b1;

    assign debounce_done = (state == DB_PRESS) && press && (timer == DB_LAST);
    assign in_hold       = (state == HELD) || (state == REPEAT);
    assign state_dbg     = state;

    // Next-state, next-timer and step request for the channel FSM.
    // On entry to DB_RELEASE the timer starts at 1 because the cycle that
    // triggered the transition was already a released sample.
    always_comb begin
        state_nx = state;
        timer_nx = timer_inc;
        fire     = 1'b0;
        case (state)
            IDLE: begin
                timer_nx = '0;
                if (armed && press) begin
                    state_nx = DB_PRESS;
                end
            end
            DB_PRESS: begin
                if (!press) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end else if (timer == DB_LAST) begin
                    timer_nx = '0;
                    if (other_in_hold || other_debounce_done) begin
                        state_nx = BLOCKED;
                    end else begin
                        fire     = 1'b1;
                        state_nx = HELD;
                    end
                end
            end
            HELD: begin
                if (!press) begin
                    state_nx = DB_RELEASE;
                    timer_nx = CNT_W'(1);
                end else if (timer == HOLD_LAST) begin
                    fire     = 1'b1;
                    state_nx = REPEAT;
                    timer_nx = '0;
                end
            end
            REPEAT: begin
                if (!press) begin
                    state_nx = DB_RELEASE;
                    timer_nx = CNT_W'(1);
                end else if (timer == REP_LAST) begin
                    fire     = 1'b1;
                    timer_nx = '0;
                end
            end
            BLOCKED: begin
                timer_nx = '0;
                if (!press) begin
                    state_nx = DB_RELEASE;
                    timer_nx = CNT_W'(1);
                end
            end
            DB_RELEASE: begin
                if (press) begin
                    timer_nx = '0;
                end else if (timer >= DB_LAST) begin
                    state_nx = IDLE;
                    timer_nx = '0;
                end
            end
            default: begin
                state_nx = IDLE;
                timer_nx = '0;
            end
        endcase
    end

    // State, timer and the registered one-cycle step pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            timer <= '0;
            pulse <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            pulse <= fire;
        end
    end

endmodule

// File: rtl/set_button_conditioner.sv
// Conditions the raw plus/minus time-setting buttons into single-cycle
// step pulses for the hour/minute digit counters. Two identical channels
// are cross-wired so that only one button can own the adjust at a time:
// a press that completes debounce while the other channel is holding, or
// in the same cycle as the other channel, is blocked for its duration.
module set_button_conditioner
    import clock_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic MCLK,
    input  logic resetSignal,
    input  logic btnPlusN,
    input  logic btnMinusN,
    output logic plus,
    output logic minus,
    output logic busy
);

    logic       plus_in_hold;
    logic       plus_db_done;
    logic [2:0] plus_state;
    logic       minus_in_hold;
    logic       minus_db_done;
    logic [2:0] minus_state;

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W)
    ) u_plus (
        .clk                 (MCLK),
        .reset_n             (resetSignal),
        .btn_n               (btnPlusN),
        .other_in_hold       (minus_in_hold),
        .other_debounce_done (minus_db_done),
        .pulse               (plus),
        .in_hold             (plus_in_hold),
        .debounce_done       (plus_db_done),
        .state_dbg           (plus_state)
    );

    button_channel #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .HOLD_CYCLES     (HOLD_CYCLES),
        .REPEAT_CYCLES   (REPEAT_CYCLES),
        .CNT_W           (CNT_W)
    ) u_minus (
        .clk                 (MCLK),
        .reset_n             (resetSignal),
        .btn_n               (btnMinusN),
        .other_in_hold       (plus_in_hold),
        .other_debounce_done (plus_db_done),
        .pulse               (minus),
        .in_hold             (minus_in_hold),
        .debounce_done       (minus_db_done),
        .state_dbg           (minus_state)
    );

    // Registered activity flag: any channel away from IDLE.
    always_ff @(posedge MCLK or negedge resetSignal) begin
        if (!resetSignal) begin
            busy <= 1'b0;
        end else begin
            busy <= (plus_state != 3'(IDLE)) || (minus_state != 3'(IDLE));
        end
    end

endmodule

// File: tb/tb_set_button_conditioner.sv
// Directed bench for set_button_conditioner with short timing
// (debounce 4, hold 20, repeat 8). Pulse times are counted in cycles
// after the raw button edge; outputs are sampled 1 ns after each posedge.
module tb_set_button_conditioner;
    import clock_pkg::*;

    logic mclk;
    logic reset_signal;
    logic btn_plus_n;
    logic btn_minus_n;
    logic plus;
    logic minus;
    logic busy;

    int tests;
    int fails;
    int cyc;
    int both_hi;
    logic [15:0] plus_q[$];
    logic [15:0] minus_q[$];
    logic [15:0] exp_q[$];

    set_button_conditioner #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (20),
        .REPEAT_CYCLES   (8),
        .CNT_W           (25)
    ) dut (
        .MCLK        (mclk),
        .resetSignal (reset_signal),
        .btnPlusN    (btn_plus_n),
        .btnMinusN   (btn_minus_n),
        .plus        (plus),
        .minus       (minus),
        .busy        (busy)
    );

    // Clock / reset block
    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    // Driver tasks
    task automatic tick();
        @(posedge mclk);
        #1;
        cyc++;
        if (plus)  plus_q.push_back(16'(cyc));
        if (minus) minus_q.push_back(16'(cyc));
        if (plus && minus) both_hi++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic start_test();
        plus_q.delete();
        minus_q.delete();
        exp_q.delete();
        cyc = 0;
    endtask

    // Scoreboard
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input bit use_minus);
        int n_obs;
        logic [15:0] o;
        n_obs = use_minus ? minus_q.size() : plus_q.size();
        tests++;
        assert (n_obs === exp_q.size()) else begin
            fails++;
            $error("FAIL %s pulse count: observed %0d expected %0d", tag, n_obs, exp_q.size());
        end
        for (int i = 0; i < exp_q.size() && i < n_obs; i++) begin
            o = use_minus ? minus_q[i] : plus_q[i];
            tests++;
            assert (o === exp_q[i]) else begin
                fails++;
                $error("FAIL %s pulse %0d cycle: observed %0d expected %0d", tag, i, o, exp_q[i]);
            end
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        both_hi = 0;
        cyc = 0;
        reset_signal = 1'b0;
        btn_plus_n = 1'b1;
        btn_minus_n = 1'b1;

        // Reset state
        @(posedge mclk);
        @(posedge mclk);
        #1;
        check("reset plus", plus, 0);
        check("reset minus", minus, 0);
        check("reset busy", busy, 0);
        check("reset plus state", dut.u_plus.state_dbg, IDLE);
        reset_signal = 1'b1;
        ticks(6);

        // 1: clean press, one pulse at cycle 7
        start_test();
        btn_plus_n = 1'b0;
        ticks(5);
        check("t1 busy during press", busy, 1);
        ticks(5);
        btn_plus_n = 1'b1;
        ticks(15);
        exp_q = '{16'd7};
        check_q("t1 plus", 1'b0);
        exp_q.delete();
        check_q("t1 minus", 1'b1);
        check("t1 busy after release", busy, 0);
        check("t1 plus state", dut.u_plus.state_dbg, IDLE);

        // 2: bouncing minus never reaches debounce
        start_test();
        btn_minus_n = 1'b0; tick();
        btn_minus_n = 1'b1; tick();
        btn_minus_n = 1'b0; tick();
        btn_minus_n = 1'b1; tick();
        btn_minus_n = 1'b0; ticks(3);
        btn_minus_n = 1'b1;
        ticks(2);
        check("t2 busy while debouncing", busy, 1);
        ticks(13);
        check_q("t2 minus", 1'b1);
        check("t2 minus state", dut.u_minus.state_dbg, IDLE);
        check("t2 busy idle", busy, 0);

        // 3: long hold, first + hold + repeat pulses
        start_test();
        btn_plus_n = 1'b0;
        ticks(60);
        btn_plus_n = 1'b1;
        ticks(20);
        exp_q = '{16'd7, 16'd27, 16'd35, 16'd43, 16'd51, 16'd59};
        check_q("t3 plus", 1'b0);
        check("t3 plus state", dut.u_plus.state_dbg, IDLE);

        // 4: plus repeating, minus pressed later is blocked
        start_test();
        btn_plus_n = 1'b0;
        ticks(30);
        btn_minus_n = 1'b0;
        ticks(15);
        check("t4 minus blocked", dut.u_minus.state_dbg, BLOCKED);
        check("t4 plus repeating", dut.u_plus.state_dbg, REPEAT);
        ticks(15);
        btn_minus_n = 1'b1;
        ticks(10);
        check("t4 minus idle", dut.u_minus.state_dbg, IDLE);
        ticks(10);
        btn_plus_n = 1'b1;
        ticks(20);
        exp_q = '{16'd7, 16'd27, 16'd35, 16'd43, 16'd51, 16'd59, 16'd67, 16'd75};
        check_q("t4 plus", 1'b0);
        exp_q.delete();
        check_q("t4 minus", 1'b1);

        // 5: simultaneous press blocks both
        start_test();
        btn_plus_n = 1'b0;
        btn_minus_n = 1'b0;
        ticks(20);
        check("t5 plus blocked", dut.u_plus.state_dbg, BLOCKED);
        check("t5 minus blocked", dut.u_minus.state_dbg, BLOCKED);
        ticks(20);
        btn_plus_n = 1'b1;
        btn_minus_n = 1'b1;
        ticks(15);
        check_q("t5 plus", 1'b0);
        check_q("t5 minus", 1'b1);
        check("t5 busy idle", busy, 0);
        check("t5 plus idle", dut.u_plus.state_dbg, IDLE);

        // 6: reset mid-press, held through reset gives no pulse
        start_test();
        btn_plus_n = 1'b0;
        ticks(5);
        reset_signal = 1'b0;
        #1;
        check("t6 async reset plus state", dut.u_plus.state_dbg, IDLE);
        check("t6 async reset busy", busy, 0);
        ticks(2);
        reset_signal = 1'b1;
        ticks(20);
        check_q("t6 held through reset", 1'b0);
        check("t6 plus state after reset", dut.u_plus.state_dbg, IDLE);
        check("t6 busy after reset", busy, 0);
        btn_plus_n = 1'b1;
        ticks(5);
        start_test();
        btn_plus_n = 1'b0;
        ticks(15);
        btn_plus_n = 1'b1;
        ticks(10);
        exp_q = '{16'd7};
        check_q("t6 re-press", 1'b0);

        check("never plus and minus together", both_hi, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/set_button_conditioner.md
Name: set_button_conditioner

Overview:
- Conditions the two raw time-setting push-buttons (plus, minus) into clean single-MCLK-cycle pulses.
- Output pulse is high for exactly one cycle, then low. The digit counters detect its falling edge as one adjust step.
- Sits directly upstream of the hour/minute digit counters and drives their plus/minus inputs.
- Adds 2-FF synchronisation, debounce, press-and-hold auto-repeat and plus/minus mutual lockout.

Parameters:
- DEBOUNCE_CYCLES, 50000: stable MCLK cycles required to accept a press or a release (1 ms at 50 MHz).
- HOLD_CYCLES, 25000000: cycles a press must be held, measured from the first pulse, before auto-repeat starts.
- REPEAT_CYCLES, 10000000: auto-repeat period once repeating.
- CNT_W, 25: timer width; must hold max(DEBOUNCE_CYCLES, HOLD_CYCLES, REPEAT_CYCLES).

Ports:
- MCLK, input, 1: system clock; all state changes on posedge.
- resetSignal, input, 1: reset, asynchronous, active-low.
- btnPlusN, input, 1: raw plus button, active-low, asynchronous, bouncing.
- btnMinusN, input, 1: raw minus button, active-low, asynchronous, bouncing.
- plus, output, 1: conditioned plus step pulse, active-high, 1 cycle wide.
- minus, output, 1: conditioned minus step pulse, active-high, 1 cycle wide.
- busy, output, 1: high while either channel is not IDLE (any press in progress).

Behaviour:
- Reset (resetSignal=0, async):
  - Both FSMs go to IDLE, timers clear, plus=minus=busy=0.
  - Synchroniser flops load 1 (released).
  - Reset asserted mid-press aborts with no pulse. After release the button must be seen released then pressed again.
- Synchroniser: 2 flops per button; the FSM uses the second-stage value. Press-level = synchronised value == 0.
- Per-channel FSM, identical for both channels, one timer each:
  - IDLE: on press-level, timer=0 and go to DB_PRESS.
  - DB_PRESS: timer counts while pressed. Release before DEBOUNCE_CYCLES returns to IDLE with no pulse. On timer reaching DEBOUNCE_CYCLES-1 while still pressed:
    - if the other channel is in HELD or REPEAT, or reaches DB_PRESS completion the same cycle, go to BLOCKED;
    - otherwise emit a 1-cycle pulse and go to HELD with timer=0.
  - HELD: on release go to DB_RELEASE. On timer reaching HOLD_CYCLES-1, emit a pulse and go to REPEAT with timer=0.
  - REPEAT: emit a pulse each time the timer reaches REPEAT_CYCLES-1, then reload 0. On release go to DB_RELEASE.
  - BLOCKED: no pulses ever. On release go to DB_RELEASE.
  - DB_RELEASE: timer counts while released; any press-level restarts the timer. After DEBOUNCE_CYCLES consecutive released cycles, go to IDLE.
- Pulse latency: the pulse is registered and asserts the cycle after the qualifying timer value. First pulse appears DEBOUNCE_CYCLES+3 cycles after the raw edge (2 sync + debounce + register).
- Pulses are never wider than 1 cycle. Consecutive pulses on one channel are at least REPEAT_CYCLES apart.
- plus and minus are never high in the same cycle.
- A held channel keeps repeating while the other button is pressed; the other channel is BLOCKED.
- Timers saturate; they never wrap.
- busy is registered and is OR of (state != IDLE) over both channels.

Decomposition:
- Shared package (clock_pkg): FSM state encoding (IDLE, DB_PRESS, HELD, REPEAT, BLOCKED, DB_RELEASE as a 3-bit enum) and default timing constants derived from the 50 MHz MCLK.
- Sub-module button_channel: synchroniser + FSM + timer for one button. It exports an inHold flag (HELD|REPEAT) and a debounceDone strobe for the lockout.
- set_button_conditioner instantiates two channels and cross-wires the lockout.

Test Plan (DEBOUNCE_CYCLES=4, HOLD_CYCLES=20, REPEAT_CYCLES=8):
1. Clean press of btnPlusN held 10 cycles, then released -> exactly one plus pulse, at cycle 7 after the edge; minus stays 0; busy returns 0 after release debounce.
2. btnMinusN bounces 0/1/0/1 at 1-cycle intervals, then stays 0 for 3 cycles and releases -> no minus pulse, FSM back in IDLE.
3. btnPlusN held 60 cycles -> pulses at cycles 7, 27, 35, 43, 51, 59 after the edge (first, hold, then every 8); none after release.
4. Plus held in REPEAT, minus pressed for 30 cycles -> plus keeps repeating; minus never pulses; minus channel BLOCKED, then IDLE after release.
5. Both buttons pressed in the same cycle and held 40 cycles -> no pulse on either output; both reach BLOCKED.
6. resetSignal pulled low at cycle 5 of a plus press while the button stays held, then deasserted -> no pulse, even if still held after reset; a new release + press yields one pulse.
